// File: rtl/pvr_tile_pkg.sv
// rtl/pvr_tile_pkg.sv - shared tile geometry, coordinate types and walker state encoding
package pvr_tile_pkg;

  localparam int TILE_W = 32;
  localparam int TILE_H = 32;

  typedef logic [10:0] coord_t;
  typedef logic [5:0]  tile_idx_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_EMIT,
    ST_DONE
  } walker_state_t;

  // Pixel base of a tile: index * 32, never wraps in 11 bits.
  function automatic coord_t tile_base(input tile_idx_t t);
    return {t, 5'd0};
  endfunction

endpackage

// File: rtl/span_prienc.sv
// rtl/span_prienc.sv - 32-bit find-first-set: lowest set bit index, its one-hot, single-bit flag
module span_prienc
  import pvr_tile_pkg::*;
(
  input  logic [TILE_W-1:0] mask,
  output logic [4:0]        index,
  output logic [TILE_W-1:0] onehot,
  output logic              single_bit
);

  always_comb begin
    index = '0;
    for (int i = TILE_W - 1; i >= 0; i--) begin
      if (mask[i]) index = 5'(i);
    end
    onehot     = mask & (~mask + TILE_W'(1));
    single_bit = (mask != '0) && ((mask & (mask - TILE_W'(1))) == '0);
  end

endmodule

// File: rtl/tile_span_walker.sv
// rtl/tile_span_walker.sv - walks the rows of one 32x32 tile, fetches each row's coverage
// mask and streams its set bits as (x, y) pixels over a valid/ready handshake
module tile_span_walker
  import pvr_tile_pkg::*;
#(
  parameter int MASK_LAT = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [5:0]        tile_x,
  input  logic [5:0]        tile_y,
  input  logic              abort,
  output logic [10:0]       x_ps,
  output logic [10:0]       y_ps,
  input  logic [TILE_W-1:0] inTri,
  output logic              pix_valid,
  input  logic              pix_ready,
  output logic [10:0]       pix_x,
  output logic [10:0]       pix_y,
  output logic              pix_eol,
  output logic              busy,
  output logic              done,
  output logic [10:0]       pix_count
);

  localparam int LAT_W = (MASK_LAT > 1) ? $clog2(MASK_LAT) : 1;

  walker_state_t     state;
  logic [4:0]        row;
  logic [LAT_W-1:0]  lat;
  // Holds the bits still to be emitted after the pixel currently presented.
  logic [TILE_W-1:0] mask_q;

  logic [TILE_W-1:0] pe_src;
  logic [4:0]        pe_index;
  logic [TILE_W-1:0] pe_onehot;
  logic              pe_single;
  logic              lat_hit;
  logic              last_row;
  logic              handshake;

  // One encoder serves both the freshly captured row and the remaining bits.
  assign pe_src    = (state == ST_REQ) ? inTri : mask_q;
  assign lat_hit   = (lat == LAT_W'(MASK_LAT - 1));
  assign last_row  = (row == 5'(TILE_H - 1));
  assign handshake = pix_valid && pix_ready;

  span_prienc u_prienc (
    .mask       (pe_src),
    .index      (pe_index),
    .onehot     (pe_onehot),
    .single_bit (pe_single)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= ST_IDLE;
      row       <= '0;
      lat       <= '0;
      mask_q    <= '0;
      x_ps      <= '0;
      y_ps      <= '0;
      pix_valid <= 1'b0;
      pix_x     <= '0;
      pix_y     <= '0;
      pix_eol   <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pix_count <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            x_ps      <= tile_base(tile_x);
            y_ps      <= tile_base(tile_y);
            row       <= '0;
            lat       <= '0;
            pix_count <= '0;
            busy      <= 1'b1;
            state     <= ST_REQ;
          end
        end

        ST_REQ: begin
          if (abort) begin
            busy  <= 1'b0;
            state <= ST_IDLE;
          end else if (!lat_hit) begin
            lat <= lat + LAT_W'(1);
          end else if (inTri == '0) begin
            if (last_row) begin
              done  <= 1'b1;
              state <= ST_DONE;
            end else begin
              row   <= row + 5'd1;
              y_ps  <= y_ps + 11'd1;
              lat   <= '0;
            end
          end else begin
            mask_q    <= inTri & ~pe_onehot;
            pix_valid <= 1'b1;
            pix_x     <= x_ps + 11'(pe_index);
            pix_y     <= y_ps;
            pix_eol   <= pe_single;
            state     <= ST_EMIT;
          end
        end

        ST_EMIT: begin
          if (abort) begin
            pix_valid <= 1'b0;
            busy      <= 1'b0;
            state     <= ST_IDLE;
          end else if (handshake) begin
            pix_count <= pix_count + 11'd1;
            if (mask_q != '0) begin
              mask_q  <= mask_q & ~pe_onehot;
              pix_x   <= x_ps + 11'(pe_index);
              pix_eol <= pe_single;
            end else begin
              pix_valid <= 1'b0;
              if (last_row) begin
                done  <= 1'b1;
                state <= ST_DONE;
              end else begin
                row   <= row + 5'd1;
                y_ps  <= y_ps + 11'd1;
                lat   <= '0;
                state <= ST_REQ;
              end
            end
          end
        end

        ST_DONE: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end

        default: begin
          pix_valid <= 1'b0;
          busy      <= 1'b0;
          state     <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
